// File: rtl/atm_pkg.sv
// Shared encodings for the ATM account arbiter: operation codes, response
// causes and the transaction FSM states.
package atm_pkg;

    localparam logic [1:0] OP_INQ = 2'b00;
    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] CAUSE_OK    = 2'b00;
    localparam logic [1:0] CAUSE_FUNDS = 2'b01;
    localparam logic [1:0] CAUSE_OVF   = 2'b10;
    localparam logic [1:0] CAUSE_LIMIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/atm_account_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from N-1 back to 0. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos_s;

    // Scan all requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = '0;
        for (int i = 0; i < N; i++) begin
            pos_s = IW'((int'(ptr) + i) % N);
            if (!any && req[pos_s]) begin
                any        = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = pos_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/atm_account_arbiter.sv
// Shared-balance owner: round-robin arbitration, one atomic read-modify-write per
// 3 cycles. Optional per-requester withdrawal limit enabled by `define ATM_WD_LIMIT_EN.
module atm_account_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int AW           = 16,
    parameter int INIT_BALANCE = 1000,
    parameter int WD_LIMIT     = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [AW*NUM_REQ-1:0] req_amount,
    input  logic                  day_clear,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_ok,
    output logic [1:0]            rsp_cause,
    output logic [AW-1:0]         rsp_balance,
    output logic                  busy,
    output logic [1:0]            state_ind
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q;
    logic [IW-1:0]        ptr_q, win_q;
    logic [NUM_REQ-1:0]   grant_q, rsp_valid_q;
    logic [1:0]           op_q, rsp_cause_q;
    logic [AW-1:0]        amt_q, bal_q, rsp_bal_q;
    logic                 rsp_ok_q, busy_q;

    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [IW-1:0]        arb_idx_s;
    logic                 arb_any_s;
    logic [1:0]           op_arr_s  [NUM_REQ];
    logic [AW-1:0]        amt_arr_s [NUM_REQ];
    logic [AW:0]          sum_s;
    logic                 lim_hit_s;
    logic                 ok_d;
    logic [1:0]           cause_d;
    logic [AW-1:0]        bal_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr_s[g]  = req_op[2*g +: 2];
        assign amt_arr_s[g] = req_amount[AW*g +: AW];
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

`ifdef ATM_WD_LIMIT_EN
    localparam logic [AW:0] LIMIT_W = (AW+1)'(WD_LIMIT);
    logic [AW-1:0] acc_q [NUM_REQ];

    assign lim_hit_s = ({1'b0, acc_q[win_q]} + {1'b0, amt_q}) > LIMIT_W;

    // Withdrawal accumulators: day_clear wipes them, an accepted withdraw lands on top.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (day_clear) acc_q[i] <= '0;
                else           acc_q[i] <= acc_q[i];
            end
            if (state_q == ST_EXEC && op_q == OP_WD && ok_d)
                acc_q[win_q] <= (day_clear ? '0 : acc_q[win_q]) + amt_q;
            else
                acc_q[win_q] <= day_clear ? '0 : acc_q[win_q];
        end
    end
`else
    logic [AW+1:0] cfg_unused_s;
    assign cfg_unused_s = {day_clear, (AW+1)'(WD_LIMIT)};
    assign lim_hit_s    = 1'b0;
`endif

    // Outcome of the latched transaction against the current balance.
    always_comb begin
        sum_s   = {1'b0, bal_q} + {1'b0, amt_q};
        ok_d    = 1'b1;
        cause_d = CAUSE_OK;
        bal_d   = bal_q;
        case (op_q)
            OP_INQ: ok_d = 1'b1;
            OP_WD: begin
                if (lim_hit_s) begin
                    ok_d    = 1'b0;
                    cause_d = CAUSE_LIMIT;
                end else if (amt_q <= bal_q) begin
                    bal_d = bal_q - amt_q;
                end else begin
                    ok_d    = 1'b0;
                    cause_d = CAUSE_FUNDS;
                end
            end
            OP_DEP: begin
                if (sum_s[AW]) begin
                    ok_d    = 1'b0;
                    cause_d = CAUSE_OVF;
                end else begin
                    bal_d = sum_s[AW-1:0];
                end
            end
            default: begin
                ok_d    = 1'b0;
                cause_d = CAUSE_OVF;
            end
        endcase
    end

    // Transaction FSM with its datapath and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            op_q        <= OP_INQ;
            amt_q       <= '0;
            bal_q       <= AW'(INIT_BALANCE);
            rsp_valid_q <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_cause_q <= CAUSE_OK;
            rsp_bal_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        win_q   <= arb_idx_s;
                        grant_q <= arb_gnt_s;
                        op_q    <= op_arr_s[arb_idx_s];
                        amt_q   <= amt_arr_s[arb_idx_s];
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    bal_q       <= bal_d;
                    rsp_valid_q <= grant_q;
                    rsp_ok_q    <= ok_d;
                    rsp_cause_q <= cause_d;
                    rsp_bal_q   <= bal_d;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_q <= '0;
                    grant_q     <= '0;
                    ptr_q       <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    rsp_valid_q <= '0;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_cause   = rsp_cause_q;
    assign rsp_balance = rsp_bal_q;
    assign busy        = busy_q;
    assign state_ind   = state_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Scoreboard bench for atm_account_arbiter: a balance/limit model queues expected
// responses; an independent negedge monitor pops and compares them.
module tb_atm_account_arbiter;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int INIT = 1000;
    localparam int LIM  = 500;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [2*N-1:0]  req_op = '0;
    logic [AW*N-1:0] req_amount = '0;
    logic            day_clear = 1'b0;
    logic [N-1:0]    grant, rsp_valid;
    logic            rsp_ok, busy;
    logic [1:0]      rsp_cause, state_ind;
    logic [AW-1:0]   rsp_balance;

    always #5 clk = ~clk;

    atm_account_arbiter #(.NUM_REQ(N), .AW(AW), .INIT_BALANCE(INIT), .WD_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
        .req_amount(req_amount), .day_clear(day_clear), .grant(grant),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_cause(rsp_cause),
        .rsp_balance(rsp_balance), .busy(busy), .state_ind(state_ind)
    );

    typedef struct { int idx; int ok; int cause; int bal; } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_bal = INIT;
    int   m_acc[N];
    int   m_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Account rules applied directly to an integer balance.
    function automatic exp_t model(input int r, input int op, input int amt);
        exp_t e;
        e.idx = r; e.ok = 1; e.cause = 0;
        case (op)
            1: begin
`ifdef ATM_WD_LIMIT_EN
                if (m_acc[r] + amt > LIM) begin e.ok = 0; e.cause = 3; end else
`endif
                if (amt <= m_bal) begin m_bal -= amt; m_acc[r] += amt; end
                else begin e.ok = 0; e.cause = 1; end
            end
            2: if (m_bal + amt > 65535) begin e.ok = 0; e.cause = 2; end
               else m_bal += amt;
            3: begin e.ok = 0; e.cause = 2; end
            default: ;
        endcase
        e.bal = m_bal;
        return e;
    endfunction

    task automatic model_reset();
        m_bal = INIT;
        m_last = 0;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        q.delete();
    endtask

    // Monitor: grant one-hot check and scoreboard pop on every response strobe.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("grant_onehot0", ($countones(grant) <= 1) ? 1 : 0, 1);
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_idx", rsp_valid, 1 << mon_e.idx);
                    chk("rsp_ok", rsp_ok, mon_e.ok);
                    chk("rsp_cause", rsp_cause, mon_e.cause);
                    chk("rsp_balance", rsp_balance, mon_e.bal);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_ok", rsp_ok, 0);
        chk("rst_rsp_cause", rsp_cause, 0);
        chk("rst_rsp_balance", rsp_balance, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_ind, 0);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic do_txn(input int r, input int op, input int amt);
        exp_t e;
        bit   seen;
        @(negedge clk);
        chk("idle_state", state_ind, 0);
        chk("hold_balance", rsp_balance, m_last);
        req_valid[r] = 1'b1;
        req_op[2*r +: 2] = 2'(op);
        req_amount[AW*r +: AW] = AW'(amt);
        e = model(r, op, amt);
        q.push_back(e);
        @(negedge clk);
        chk("exec_grant", grant, 1 << r);
        chk("exec_busy", busy, 1);
        chk("exec_state", state_ind, 1);
        @(negedge clk);
        chk("latency", rsp_valid[r], 1);
        seen = rsp_valid[r];
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid[r];
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: no response for requester %0d", r);
        end
        req_valid[r] = 1'b0;
        m_last = e.bal;
    endtask

    task automatic pulse_day_clear();
        @(negedge clk);
        day_clear = 1'b1;
        @(negedge clk);
        day_clear = 1'b0;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
    endtask

    initial begin
        exp_t e;
        int   cnt, last_cyc, r, op, amt;

        do_reset();
        do_txn(0, 0, 0);          // balance visible after reset
        do_txn(0, 1, 300);        // withdraw -> 700
        do_txn(1, 1, 701);        // insufficient
        do_txn(1, 1, 700);        // exact -> 0
        do_txn(1, 2, 65000);      // -> 65000
        do_txn(2, 2, 600);        // overflow
        do_txn(3, 3, 5);          // illegal op
        do_txn(2, 1, 300);
        do_txn(2, 1, 300);        // limit hit only with the limit feature
        pulse_day_clear();
        do_txn(2, 1, 300);

        for (int t = 0; t < 70; t++) begin
            r  = $urandom_range(0, N - 1);
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: amt = m_bal;
                1: amt = (m_bal < 65535) ? m_bal + 1 : m_bal;
                2: amt = 65535 - m_bal;
                3: amt = (m_bal > 0) ? 65536 - m_bal : 65535;
                4: amt = $urandom_range(0, 65535);
                default: amt = $urandom_range(0, 400);
            endcase
            if ($urandom_range(0, 7) == 0) pulse_day_clear();
            do_txn(r, op, amt);
        end

        // All four requesters held from reset: strict rotation, 3-cycle spacing.
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'b01;
            req_amount[AW*i +: AW] = AW'(10 * (i + 1));
        end
        @(negedge clk);
        model_reset();
        for (int i = 0; i < 5; i++) begin
            e = model(i % N, 1, 10 * ((i % N) + 1));
            q.push_back(e);
        end
        reset_n = 1'b1;
        cnt = 0;
        last_cyc = 0;
        for (int k = 0; k < 40 && cnt < 5; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (cnt > 0) chk("rr_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                cnt++;
            end
        end
        req_valid = '0;
        chk("rr_count", cnt, 5);
        m_last = e.bal;

        // Reset while a transaction is executing: no response, balance restored.
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_op[6 +: 2] = 2'b01;
        req_amount[3*AW +: AW] = 16'd100;
        @(negedge clk);
        chk("abort_busy", busy, 1);
        reset_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_grant", grant, 0);
        chk("abort_busy_clr", busy, 0);
        model_reset();
        reset_n = 1'b1;
        do_txn(3, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
